// File: rtl/clause_dispatcher_pkg.sv
// Shared SAT-solver definitions: engine/clause geometry, clause type and
// dispatcher state codes used by the arbiter and the engines.
package clause_dispatcher_pkg;

  localparam int SAT_NUM_ENGINE      = 4;
  localparam int SAT_CLA_LENGTH      = 3;
  localparam int SAT_VARIABLE_LENGTH = 11;
  localparam int SAT_CW              = SAT_VARIABLE_LENGTH * SAT_CLA_LENGTH;

  typedef logic [SAT_CW-1:0] clause_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/clause_dispatcher_slot_allocator.sv
// Combinational prefix allocator: maps accepted non-padding clauses, in order,
// onto free holding slots in ascending engine index.
module slot_allocator
  import clause_dispatcher_pkg::*;
#(
  parameter int NUM_ENGINE = SAT_NUM_ENGINE,
  localparam int CNT_W = $clog2(NUM_ENGINE) + 1,
  localparam int SEL_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1
) (
  input  logic [NUM_ENGINE-1:0]            free_mask,
  input  logic [NUM_ENGINE-1:0]            pad_mask,
  input  logic [CNT_W-1:0]                 offer_cnt,
  output logic [NUM_ENGINE-1:0]            load_en,
  output logic [NUM_ENGINE-1:0][SEL_W-1:0] sel,
  output logic [CNT_W-1:0]                 accept_cnt
);

  logic [CNT_W-1:0]                 free_n;
  logic [CNT_W-1:0]                 real_n;
  logic [CNT_W-1:0]                 rank;
  logic [NUM_ENGINE-1:0][SEL_W-1:0] real_idx;

  always_comb begin
    free_n = '0;
    for (int s = 0; s < NUM_ENGINE; s++)
      free_n = free_n + CNT_W'(free_mask[s]);
    accept_cnt = (offer_cnt < free_n) ? offer_cnt : free_n;

    // Padding clauses are consumed but claim no slot, so only real ones are ranked.
    real_n   = '0;
    real_idx = '0;
    for (int c = 0; c < NUM_ENGINE; c++) begin
      if ((CNT_W'(c) < accept_cnt) && !pad_mask[c]) begin
        real_idx[real_n[SEL_W-1:0]] = SEL_W'(c);
        real_n = real_n + CNT_W'(1);
      end
    end

    rank    = '0;
    load_en = '0;
    sel     = '0;
    for (int s = 0; s < NUM_ENGINE; s++) begin
      if (free_mask[s]) begin
        if (rank < real_n) begin
          load_en[s] = 1'b1;
          sel[s]     = real_idx[rank[SEL_W-1:0]];
        end
        rank = rank + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clause_dispatcher.sv
// Clause dispatcher: pulls clauses from the latency buffer into one holding
// slot per engine and hands them off when the engine is ready.
module clause_dispatcher
  import clause_dispatcher_pkg::*;
#(
  parameter int NUM_ENGINE      = SAT_NUM_ENGINE,
  parameter int CLA_LENGTH      = SAT_CLA_LENGTH,
  parameter int VARIABLE_LENGTH = SAT_VARIABLE_LENGTH,
  parameter int CW              = VARIABLE_LENGTH * CLA_LENGTH,
  localparam int CNT_W = $clog2(NUM_ENGINE) + 1,
  localparam int SEL_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start_in,
  input  logic                          empty_in,
  input  logic [CNT_W-1:0]              clause_released_in,
  input  logic [NUM_ENGINE-1:0][CW-1:0] clause_in,
  input  logic                          abort_in,
  input  logic [NUM_ENGINE-1:0]         eng_ready_in,
  input  logic [NUM_ENGINE-1:0]         eng_busy_in,
  output logic [CNT_W-1:0]              clause_received_out,
  output logic [NUM_ENGINE-1:0]         eng_valid_out,
  output logic [NUM_ENGINE-1:0][CW-1:0] eng_clause_out,
  output logic [15:0]                   dispatched_cnt_out,
  output logic                          done_out
);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CNT_W-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [1:0]                    state;
  logic [NUM_ENGINE-1:0]         slot_valid;
  logic [NUM_ENGINE-1:0][CW-1:0] slot_clause;
  logic [15:0]                   dispatched_cnt;

  logic [CNT_W-1:0]                 released;
  logic [CNT_W-1:0]                 offer;
  logic [NUM_ENGINE-1:0]            pad_mask;
  logic [NUM_ENGINE-1:0]            handoff;
  logic [CNT_W-1:0]                 n_handoff;
  logic [NUM_ENGINE-1:0]            load_en;
  logic [NUM_ENGINE-1:0][SEL_W-1:0] sel;
  logic [CNT_W-1:0]                 accept_cnt;

  always_comb begin
    released = (clause_released_in > CNT_W'(NUM_ENGINE)) ? CNT_W'(NUM_ENGINE)
                                                          : clause_released_in;
    offer    = ((state == ST_RUN) && !abort_in) ? released : '0;
    handoff  = slot_valid & eng_ready_in;
    n_handoff = '0;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      pad_mask[i] = (clause_in[i] == '0);
      n_handoff   = n_handoff + CNT_W'(handoff[i]);
    end
  end

  slot_allocator #(.NUM_ENGINE(NUM_ENGINE)) u_alloc (
    .free_mask  (~slot_valid),
    .pad_mask   (pad_mask),
    .offer_cnt  (offer),
    .load_en    (load_en),
    .sel        (sel),
    .accept_cnt (accept_cnt)
  );

  // Slot and state registers; abort wins over handoff, load and transitions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      slot_valid     <= '0;
      slot_clause    <= '0;
      dispatched_cnt <= '0;
    end else if (abort_in) begin
      state      <= ST_IDLE;
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINE; i++) begin
        if (load_en[i]) begin
          slot_valid[i]  <= 1'b1;
          slot_clause[i] <= clause_in[sel[i]];
        end else if (handoff[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end

      if ((state == ST_IDLE) && start_in)
        dispatched_cnt <= '0;
      else
        dispatched_cnt <= sat_add(dispatched_cnt, n_handoff);

      case (state)
        ST_IDLE:  if (start_in) state <= ST_RUN;
        ST_RUN:   if (empty_in && (accept_cnt == '0)) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!empty_in)
            state <= ST_RUN;
          else if ((slot_valid == '0) && (eng_busy_in == '0))
            state <= ST_DONE;
        end
        ST_DONE:  if (!start_in) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign clause_received_out = reset ? '0 : accept_cnt;
  assign eng_valid_out       = slot_valid & {NUM_ENGINE{~reset}};
  assign eng_clause_out      = slot_clause;
  assign dispatched_cnt_out  = dispatched_cnt;
  assign done_out            = (state == ST_DONE) && !reset;

endmodule

// File: tb/tb_clause_dispatcher.sv
// Bench for clause_dispatcher: directed scenarios plus random traffic against
// a queue-based reference model of the dispatch rules.
module tb_clause_dispatcher;
  import clause_dispatcher_pkg::*;

  localparam int N = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      start;
  logic                      empty;
  logic [2:0]                released;
  logic [N-1:0][SAT_CW-1:0]  clauses;
  logic                      abort;
  logic [N-1:0]              ready;
  logic [N-1:0]              busy;
  logic [2:0]                received;
  logic [N-1:0]              eng_valid;
  logic [N-1:0][SAT_CW-1:0]  eng_clause;
  logic [15:0]               dispatched;
  logic                      done;

  clause_dispatcher dut (
    .clock               (clk),
    .reset               (reset),
    .start_in            (start),
    .empty_in            (empty),
    .clause_released_in  (released),
    .clause_in           (clauses),
    .abort_in            (abort),
    .eng_ready_in        (ready),
    .eng_busy_in         (busy),
    .clause_received_out (received),
    .eng_valid_out       (eng_valid),
    .eng_clause_out      (eng_clause),
    .dispatched_cnt_out  (dispatched),
    .done_out            (done)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  int      checks = 0;
  int      errors = 0;
  bit      mvalid[N];
  clause_t mclause[N];
  int      mstate = M_IDLE;
  int      mcnt = 0;
  int      last_recv;
  string   scen;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_k();
    int rel, nfree;
    if (reset || abort || mstate != M_RUN) return 0;
    rel = (released > 3'd4) ? 4 : int'(released);
    nfree = 0;
    for (int i = 0; i < N; i++) if (!mvalid[i]) nfree++;
    return (rel < nfree) ? rel : nfree;
  endfunction

  task automatic model_update(int k);
    bit nv[N];
    int q[$];
    int hand, s;
    bit all_idle;
    if (reset) begin
      for (int i = 0; i < N; i++) begin mvalid[i] = 0; mclause[i] = '0; end
      mstate = M_IDLE; mcnt = 0;
      return;
    end
    if (abort) begin
      for (int i = 0; i < N; i++) mvalid[i] = 0;
      mstate = M_IDLE;
      return;
    end
    all_idle = (busy == '0);
    hand = 0;
    for (int i = 0; i < N; i++) begin
      if (mvalid[i]) all_idle = 0;
      if (!mvalid[i]) q.push_back(i);
      if (mvalid[i] && ready[i]) begin hand++; nv[i] = 0; end
      else nv[i] = mvalid[i];
    end
    for (int c = 0; c < k; c++) begin
      if (clauses[c] != '0) begin
        s = q.pop_front();
        nv[s] = 1;
        mclause[s] = clauses[c];
      end
    end
    for (int i = 0; i < N; i++) mvalid[i] = nv[i];
    if (mstate == M_IDLE && start) mcnt = 0;
    else mcnt = (mcnt + hand > 65535) ? 65535 : mcnt + hand;
    case (mstate)
      M_IDLE:  if (start) mstate = M_RUN;
      M_RUN:   if (empty && k == 0) mstate = M_DRAIN;
      M_DRAIN: if (!empty) mstate = M_RUN; else if (all_idle) mstate = M_DONE;
      default: if (!start) mstate = M_IDLE;
    endcase
  endtask

  task automatic step();
    int k;
    logic [N-1:0] ev;
    #1;
    k = model_k();
    last_recv = int'(received);
    chk({scen, "_recv"}, received, k);
    @(posedge clk);
    model_update(k);
    @(negedge clk);
    for (int i = 0; i < N; i++) ev[i] = mvalid[i] & ~reset;
    chk({scen, "_valid"}, eng_valid, ev);
    for (int i = 0; i < N; i++) chk({scen, "_clause"}, eng_clause[i], mclause[i]);
    chk({scen, "_cnt"}, dispatched, mcnt);
    chk({scen, "_done"}, done, (mstate == M_DONE) && !reset);
  endtask

  task automatic idle_inputs();
    start = 0; empty = 0; released = 0; clauses = '0;
    abort = 0; ready = 0; busy = 0;
  endtask

  function automatic clause_t rnd_clause();
    return {$urandom, $urandom};
  endfunction

  clause_t ca, cb, cc, c0, c2, c3;

  initial begin
    for (int i = 0; i < N; i++) begin mvalid[i] = 0; mclause[i] = '0; end
    reset = 1; idle_inputs();
    @(negedge clk);
    scen = "reset";
    step(); step();
    chk("reset_valid0", eng_valid, 4'b0000);
    chk("reset_cnt0", dispatched, 0);
    reset = 0;

    // All slots free, three clauses offered.
    scen = "s1";
    start = 1; step();
    ca = 33'h1_2345_6789; cb = 33'h0_0000_0ABC; cc = 33'h1_FFFF_0001;
    released = 3; clauses = {33'h0, cc, cb, ca};
    step();
    chk("s1_recv3", last_recv, 3);
    chk("s1_valid0111", eng_valid, 4'b0111);
    chk("s1_slot0", eng_clause[0], ca);
    chk("s1_slot2", eng_clause[2], cc);

    // Slots 0 and 2 full, four offered: two land in slots 1 and 3.
    scen = "s2";
    released = 0; clauses = '0; ready = 4'b0010; step();
    ready = 0; released = 4;
    clauses = {33'h4, 33'h3, 33'h1_0000_0002, 33'h0_8000_0001};
    step();
    chk("s2_recv2", last_recv, 2);
    chk("s2_valid", eng_valid, 4'b1111);
    chk("s2_slot1", eng_clause[1], 33'h0_8000_0001);
    chk("s2_slot3", eng_clause[3], 33'h1_0000_0002);

    // Padding clause in position 1 leaves its slot for the next clause.
    scen = "s3";
    released = 0; clauses = '0; ready = 4'b1111; step();
    ready = 0; released = 4;
    c0 = 33'h0_AAAA_5555; c2 = 33'h1_5555_AAAA; c3 = 33'h0_0F0F_F0F0;
    clauses = {c3, c2, 33'h0, c0};
    step();
    chk("s3_recv4", last_recv, 4);
    chk("s3_valid0111", eng_valid, 4'b0111);
    chk("s3_slot1", eng_clause[1], c2);
    chk("s3_slot2", eng_clause[2], c3);

    // Drain with busy falling last.
    scen = "s4";
    released = 0; clauses = '0; empty = 1; ready = 4'b1111; busy = 4'b1111;
    step();
    chk("s4_notdone", done, 0);
    step();
    busy = 0; step();
    chk("s4_done", done, 1);
    chk("s4_cnt8", dispatched, 8);
    start = 0; step();
    chk("s4_idle", done, 0);

    // Abort with all slots full and ready.
    scen = "s5";
    start = 1; empty = 0; ready = 0; step();
    chk("s5_cntclr", dispatched, 0);
    released = 4;
    clauses = {rnd_clause() | 33'h1, rnd_clause() | 33'h1, rnd_clause() | 33'h1, rnd_clause() | 33'h1};
    step();
    abort = 1; ready = 4'b1111; step();
    chk("s5_recv0", last_recv, 0);
    chk("s5_valid0", eng_valid, 4'b0000);
    chk("s5_nohand", dispatched, 0);
    abort = 0; start = 0; step();
    chk("s5_idle_recv0", last_recv, 0);

    // Reset mid-run with full slots, then restart.
    scen = "s6";
    start = 1; ready = 0; released = 0; step();
    released = 4; step();
    reset = 1; ready = 4'b1111; step();
    chk("s6_valid0", eng_valid, 4'b0000);
    chk("s6_cnt0", dispatched, 0);
    reset = 0; idle_inputs(); step();
    start = 1; step();
    released = 3; clauses = {33'h0, cc, cb, ca}; step();
    chk("s6_recv3", last_recv, 3);
    chk("s6_valid0111", eng_valid, 4'b0111);

    // Random traffic.
    scen = "rnd";
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 9) != 0);
      empty    = ($urandom_range(0, 3) == 0);
      released = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++)
        clauses[i] = ($urandom_range(0, 3) == 0) ? '0 : rnd_clause();
      ready    = 4'($urandom);
      busy     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
